// File: rtl/bch_enc.sv
// bch_enc: systematic serial BCH encoder built on an r-bit Galois LFSR.
// Message bits stream through with one cycle of latency; the r parity bits
// follow back-to-back. Optional feature: define BCH_ENC_CW_CNT_EN to add the
// 16-bit completed-codeword counter output cw_cnt.
module bch_enc #(
  parameter int N_MAX = 1023,
  parameter int T_MAX = 4,
  parameter int M_MAX = 10,
  localparam int R_MAX = T_MAX * M_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       n,
  input  logic [5:0]       r,
  input  logic [R_MAX-1:0] gen,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  output logic             done,
  output logic             cfg_err
`ifdef BCH_ENC_CW_CNT_EN
  ,
  output logic [15:0]      cw_cnt
`endif
);

  localparam int CNT_W = $clog2(N_MAX + 1);

  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;       // message bits accepted, then parity bits sent
  logic [CNT_W-1:0]   k_q;       // message length n - r
  logic [5:0]         r_q;
  logic [R_MAX-1:0]   gen_q;
  logic [R_MAX-1:0]   lfsr, lfsr_nxt, lfsr_shl;
  logic               cfg_bad, accept, msg_last, par_last, top, fb;

  assign cfg_bad  = (r == '0) || (int'(r) > R_MAX) || ({4'b0, r} >= n);
  assign accept   = in_valid && (state == MSG);
  assign msg_last = (cnt == k_q - 1'b1);
  assign par_last = (cnt == CNT_W'(r_q) - 1'b1);
  assign lfsr_shl = {lfsr[R_MAX-2:0], 1'b0};
  assign fb       = in_bit ^ top;

  // Tap the current top stage lfsr[r-1] and form the next LFSR value.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    top      = 1'b0;
    lfsr_nxt = '0;
    for (int i = 0; i < R_MAX; i++) begin
      if (i == int'(r_q) - 1) top = lfsr[i];
    end
    for (int i = 0; i < R_MAX; i++) begin
      if (i < int'(r_q)) begin
        // Parity drain is a plain shift with zero fill; division adds g(x) on feedback.
        lfsr_nxt[i] = (state == PAR) ? lfsr_shl[i] : (lfsr_shl[i] ^ (fb & gen_q[i]));
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the in_ready handshake.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: if (start && !cfg_bad) state_nxt = MSG;
      MSG: begin
        in_ready = 1'b1;
        if (accept && msg_last) state_nxt = PAR;
      end
      PAR:     if (par_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: configuration latch, LFSR, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q       <= '0;
      r_q       <= '0;
      gen_q     <= '0;
      lfsr      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              k_q   <= CNT_W'(n - {4'b0, r});
              r_q   <= r;
              gen_q <= gen;
              lfsr  <= '0;
              cnt   <= '0;
            end
          end
        end
        MSG: begin
          if (accept) begin
            lfsr      <= lfsr_nxt;
            out_valid <= 1'b1;
            out_bit   <= in_bit;
            cnt       <= msg_last ? '0 : cnt + 1'b1;
          end
        end
        PAR: begin
          lfsr      <= lfsr_nxt;
          out_valid <= 1'b1;
          out_bit   <= top;
          cnt       <= cnt + 1'b1;
          if (par_last) begin
            out_last <= 1'b1;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCH_ENC_CW_CNT_EN
  // Completed-codeword counter; moves on the same edge that raises done.
  always_ff @(posedge clk) begin
    if (rst)                          cw_cnt <= '0;
    else if (state == PAR && par_last) cw_cnt <= cw_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/bch_enc.md
BCH_ENC -- requirements
Module: bch_enc

Interface
REQ-001 Parameters SHALL be:
- N_MAX, default 1023, maximum codeword length.
- T_MAX, default 4, maximum correctable errors.
- M_MAX, default 10, maximum field degree.
- Parity register width is R_MAX = T_MAX*M_MAX.

REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one codeword.
- n  in  10  codeword length.
- r  in  6  parity length, equal to deg g(x).
- gen  in  R_MAX  generator coefficients; bit i = g_i for i < r; g_r = 1 is implicit.
- in_valid  in  1  message bit valid.
- in_bit  in  1  message bit; highest-degree bit first.
- in_ready  out  1  encoder accepts a message bit.
- out_valid  out  1  codeword bit valid.
- out_bit  out  1  codeword bit; message bits first, then parity, highest degree first.
- out_last  out  1  final codeword bit.
- done  out  1  one-cycle pulse at codeword completion.
- cfg_err  out  1  one-cycle pulse when start carries an illegal configuration.

Function
REQ-003 The block SHALL be a systematic serial LFSR encoder with states IDLE, MSG and PAR.
REQ-004 In IDLE, start=1 SHALL latch n, r and gen, clear the R_MAX-bit LFSR and the bit counter, and enter MSG on the next cycle.
REQ-005 start SHALL be illegal if r==0, r>R_MAX or r>=n. An illegal start SHALL pulse cfg_err in the next cycle and the block SHALL stay in IDLE.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 in_ready SHALL be 1 only in MSG. A bit SHALL be accepted only when in_valid and in_ready are both 1. in_valid in other states SHALL have no effect.
REQ-008 For each accepted bit, the LFSR SHALL update as follows:
- fb = in_bit XOR lfsr[r-1].
- lfsr[i] <= lfsr[i-1] XOR (fb AND gen[i]) for 0<i<r.
- lfsr[0] <= fb AND gen[0].
- Bits at index r and above SHALL stay 0.
REQ-009 Each bit accepted in cycle c SHALL appear on out_bit with out_valid=1 in cycle c+1, a registered single-cycle latency. Idle gaps in in_valid SHALL produce out_valid=0 cycles.
REQ-010 After the (n-r)th message bit is accepted in cycle c, the state SHALL become PAR in cycle c+1.
REQ-011 In PAR, one parity bit per cycle SHALL be emitted (lfsr[r-1], then a shift with 0 fill). The r parity bits SHALL appear contiguously in cycles c+2 through c+1+r.
REQ-012 out_last and done SHALL assert together with the r-th parity bit. The state SHALL return to IDLE in that same cycle, so that a new start is accepted in that cycle at the earliest.
REQ-013 out_valid SHALL be 0 in every cycle that carries no codeword bit.

Reset
REQ-014 rst=1 at a clock edge SHALL force IDLE and clear the LFSR, the counter and all latched configuration.
REQ-015 rst SHALL force every output to 0: in_ready, out_valid, out_bit, out_last, done and cfg_err.
REQ-016 rst asserted mid-codeword SHALL abandon the codeword with no out_last and no done.

Configuration
REQ-017 Macro BCH_ENC_CW_CNT_EN SHALL control a codeword counter.
- Defined: add output cw_cnt (16 bits). It increments on each done, wraps at 0xFFFF->0 and resets to 0 on rst.
- Undefined: the port and the counter SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-018 Hamming(7,4): n=7, r=3, gen=0b011, message 0001 -> out bits 0,0,0,1,0,1,1; out_last and done on the 7th bit.
REQ-019 BCH(15,7): n=15, r=8, gen=0xD1, message 0000001 -> codeword 0000001 11010001. Message all zeros -> 15 zero bits.
REQ-020 Same as REQ-019 with in_valid toggling 1,0,1,0 -> output bits unchanged, out_valid gaps mirror the input gaps, and the parity burst is contiguous.
REQ-021 start with r=0, then with r=15 at n=15 -> cfg_err pulses, in_ready stays 0 and no output is produced. start during MSG -> ignored, and the current codeword completes correctly.
REQ-022 rst after 3 message bits of a BCH(15,7) codeword -> all outputs 0 the next cycle. A following start encodes a fresh codeword correctly. With BCH_ENC_CW_CNT_EN defined, two completed codewords -> cw_cnt=2.
